// File: rtl/catraca_pkg.sv
// catraca_pkg: shared types and constants for the two-reader turnstile
// controller.
//   state_t          controller states (locked, open, releasing)
//   *_DEF            default parameter values for the top and its counters
//   READER1/READER2  reader index constants
//   reader_onehot    maps a reader index to its one-hot grant code
package catraca_pkg;

  localparam int MAX_CREDIT_DEF  = 5;
  localparam int CREDIT_W_DEF    = 3;
  localparam int OPEN_CYCLES_DEF = 4;

  localparam logic READER1 = 1'b0;
  localparam logic READER2 = 1'b1;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic [1:0] reader_onehot(input logic idx);
    reader_onehot = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/catraca_arbiter_credit_counter.sv
// credit_counter: the saturating credit balance of one card reader.
//   clk_2, reset  clock and asynchronous active-high reset
//   load          credits to add; only the cycle it leaves 00 counts
//   debit         remove one credit (passage granted)
//   refund        return one credit (passage timed out)
//   credit        registered balance
//   zero          balance is empty
module credit_counter
  import catraca_pkg::*;
#(
  parameter int MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [1:0]          load,
  input  logic                debit,
  input  logic                refund,
  output logic [CREDIT_W-1:0] credit,
  output logic                zero
);

  // Two spare bits so credit + 3 + 1 can never wrap before saturation.
  localparam int SUM_W = CREDIT_W + 2;

  logic [1:0]          load_prev_r;
  logic [1:0]          load_add_s;
  logic [SUM_W-1:0]    sum_s;
  logic [CREDIT_W-1:0] credit_next_s;
  logic [CREDIT_W-1:0] credit_r;

  // Load edge detect: a held switch value adds credits only once.
  always_comb begin
    load_add_s = 2'b00;
    if (load_prev_r == 2'b00) begin
      load_add_s = load;
    end else begin
      load_add_s = 2'b00;
    end
  end

  // Next balance; the arbiter only debits a non-empty balance, so the
  // subtraction cannot underflow.
  always_comb begin
    sum_s = SUM_W'(credit_r) + SUM_W'(load_add_s) + SUM_W'(refund) - SUM_W'(debit);
    credit_next_s = credit_r;
    if (sum_s > SUM_W'(MAX_CREDIT)) begin
      credit_next_s = CREDIT_W'(MAX_CREDIT);
    end else begin
      credit_next_s = sum_s[CREDIT_W-1:0];
    end
  end

  // Balance and load-history registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      credit_r    <= {CREDIT_W{1'b0}};
      load_prev_r <= 2'b00;
    end else begin
      credit_r    <= credit_next_s;
      load_prev_r <= load;
    end
  end

  assign credit = credit_r;
  assign zero   = (credit_r == {CREDIT_W{1'b0}});

endmodule

// File: rtl/catraca_arbiter.sv
// catraca_arbiter: shares one turnstile between two card readers.
// Simultaneous requests are served round-robin, each passage costs one
// credit, and a passage that times out without rotation is refunded.
//   clk_2, reset      clock and asynchronous active-high reset
//   pass_req[1:0]     level requests (bit0 reader 1, bit1 reader 2)
//   load1, load2      credits to add (counted once per 00->nonzero edge)
//   passed            turnstile rotation sensor
//   unlock            turnstile released (registered)
//   grant[1:0]        one-hot granted reader, 00 when idle (registered)
//   denied            a requester has no credit while locked
//   credit1, credit2  balances (registered)
//   disp_value        balance to show on the display
module catraca_arbiter
  import catraca_pkg::*;
#(
  parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
  parameter int CREDIT_W    = CREDIT_W_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic [1:0]          pass_req,
  input  logic [1:0]          load1,
  input  logic [1:0]          load2,
  input  logic                passed,
  output logic                unlock,
  output logic [1:0]          grant,
  output logic                denied,
  output logic [CREDIT_W-1:0] credit1,
  output logic [CREDIT_W-1:0] credit2,
  output logic [CREDIT_W-1:0] disp_value
);

  localparam int TIMER_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  state_t              state_r, state_n_s;
  logic                rr_r, rr_n_s;
  logic [TIMER_W-1:0]  timer_r, timer_n_s;
  logic [1:0]          grant_r, grant_n_s;
  logic                unlock_r, unlock_n_s;
  logic [1:0]          debit_s, refund_s, zero_s, eligible_s;
  logic                pick_s;
  logic [CREDIT_W-1:0] credit1_s, credit2_s;

  credit_counter #(.MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W)) u_credit1 (
    .clk_2  (clk_2),
    .reset  (reset),
    .load   (load1),
    .debit  (debit_s[0]),
    .refund (refund_s[0]),
    .credit (credit1_s),
    .zero   (zero_s[0])
  );

  credit_counter #(.MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W)) u_credit2 (
    .clk_2  (clk_2),
    .reset  (reset),
    .load   (load2),
    .debit  (debit_s[1]),
    .refund (refund_s[1]),
    .credit (credit2_s),
    .zero   (zero_s[1])
  );

  assign eligible_s = pass_req & ~zero_s;

  // Next-state logic: arbitration, open-window timer, release wait.
  always_comb begin
    state_n_s  = state_r;
    rr_n_s     = rr_r;
    timer_n_s  = timer_r;
    grant_n_s  = grant_r;
    unlock_n_s = unlock_r;
    debit_s    = 2'b00;
    refund_s   = 2'b00;
    pick_s     = READER1;
    case (state_r)
      ST_LOCKED: begin
        if (eligible_s != 2'b00) begin
          if (eligible_s == 2'b11) begin
            pick_s = rr_r;
          end else if (eligible_s[1]) begin
            pick_s = READER2;
          end else begin
            pick_s = READER1;
          end
          grant_n_s  = reader_onehot(pick_s);
          debit_s    = reader_onehot(pick_s);
          unlock_n_s = 1'b1;
          timer_n_s  = {TIMER_W{1'b0}};
          rr_n_s     = ~pick_s;
          state_n_s  = ST_OPEN;
        end else begin
          grant_n_s  = 2'b00;
          unlock_n_s = 1'b0;
        end
      end
      ST_OPEN: begin
        if (passed) begin
          // Rotation wins over a simultaneous timeout: no refund.
          unlock_n_s = 1'b0;
          state_n_s  = ST_RELEASE;
        end else if (timer_r == TIMER_W'(OPEN_CYCLES - 1)) begin
          unlock_n_s = 1'b0;
          refund_s   = grant_r;
          state_n_s  = ST_RELEASE;
        end else begin
          timer_n_s = timer_r + TIMER_W'(1);
        end
      end
      ST_RELEASE: begin
        // Hold until the granted reader lets go, so one press is one passage.
        if ((pass_req & grant_r) == 2'b00) begin
          grant_n_s = 2'b00;
          state_n_s = ST_LOCKED;
        end else begin
          state_n_s = ST_RELEASE;
        end
      end
      default: begin
        grant_n_s  = 2'b00;
        unlock_n_s = 1'b0;
        state_n_s  = ST_LOCKED;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_r  <= ST_LOCKED;
      rr_r     <= READER1;
      timer_r  <= {TIMER_W{1'b0}};
      grant_r  <= 2'b00;
      unlock_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      rr_r     <= rr_n_s;
      timer_r  <= timer_n_s;
      grant_r  <= grant_n_s;
      unlock_r <= unlock_n_s;
    end
  end

  // Display selection: granted reader first, then whoever is pressing.
  always_comb begin
    disp_value = credit1_s;
    if (grant_r == 2'b01) begin
      disp_value = credit1_s;
    end else if (grant_r == 2'b10) begin
      disp_value = credit2_s;
    end else if (pass_req[0]) begin
      disp_value = credit1_s;
    end else if (pass_req[1]) begin
      disp_value = credit2_s;
    end else begin
      disp_value = credit1_s;
    end
  end

  assign denied  = (state_r == ST_LOCKED) && ((pass_req & zero_s) != 2'b00)
                   && (eligible_s == 2'b00);
  assign unlock  = unlock_r;
  assign grant   = grant_r;
  assign credit1 = credit1_s;
  assign credit2 = credit2_s;

endmodule
